// File: rtl/nios2_oci_trace_monitor.sv
// rtl/nios2_oci_trace_monitor.sv - capture FIFO for Nios II OCI trace words with end-of-test drain sequencing
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   dct_buffer/count    : trace word and its fragment-count tag
//   dct_valid           : one-cycle strobe qualifying dct_buffer/dct_count
//   test_ending         : CPU is finishing; stop capturing
//   test_has_ended      : CPU has finished
//   rd_data/valid/ready : show-ahead read port, rd_data = {dct_count, dct_buffer}
//   level               : FIFO occupancy 0..DEPTH
//   overflow            : sticky dropped-word flag
//   drop_count          : saturating dropped-word count
//   drained             : end-of-test drain complete
//   state               : CAPTURE=0, DRAIN=1, DONE=2
module nios2_oci_trace_monitor #(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DCT_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]       dct_count,
  input  logic                   dct_valid,
  input  logic                   test_ending,
  input  logic                   test_has_ended,
  output logic [CNT_W+DCT_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  output logic                   drained,
  output logic [1:0]             state
);

  localparam int LVL_W = ADDR_W + 1;
  localparam int WORD_W = CNT_W + DCT_W;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_q, drop_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic push_req;
  logic push_ok;
  logic pop;
  logic full;
  logic drop;

  // Full/empty come from the occupancy counter; the pointers alone cannot
  // distinguish full from empty when they are equal.
  assign full     = (level_q == LVL_W'(DEPTH));
  assign rd_valid = (level_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];

  // A zero fragment count is a null strobe and never reaches the FIFO.
  assign push_req = (state_q == CAPTURE) && dct_valid && (dct_count != '0);
  assign pop      = rd_valid && rd_ready;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  // Datapath next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  // FSM next-state; DRAIN->DONE looks at post-pop occupancy so the last pop
  // and the transition share an edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: begin
        if (test_ending || test_has_ended) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((level_d == '0) && test_has_ended) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage array is not reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= {dct_count, dct_buffer};
    end
  end

  // FSM outputs
  always_comb begin
    state      = state_q;
    drained    = (state_q == DONE);
    level      = level_q;
    overflow   = overflow_q;
    drop_count = drop_q;
  end

endmodule
